// File: rtl/eth_phy_10g_rx_sync.sv
// 10GBASE-R receive block synchronizer: sync-header block lock, bitslip control,
// self-synchronous payload descrambler and 125 us BER monitor.
module eth_phy_10g_rx_sync #(
    parameter int          DATA_WIDTH        = 64,
    parameter int          HDR_WIDTH         = 2,
    parameter bit          BIT_REVERSE       = 1'b0,
    parameter bit          SCRAMBLER_DISABLE = 1'b0,
    parameter int unsigned BITSLIP_HOLDOFF   = 7,
    parameter int unsigned COUNT_125US       = 19531
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] serdes_rx_data,
    input  logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
    output logic                  serdes_rx_bitslip,
    output logic [DATA_WIDTH-1:0] encoded_rx_data,
    output logic [HDR_WIDTH-1:0]  encoded_rx_hdr,
    output logic                  rx_bad_block,
    output logic                  rx_block_lock,
    output logic                  rx_high_ber,
    output logic                  rx_status
);

    localparam int unsigned TimerW = (COUNT_125US > 1) ? $clog2(COUNT_125US) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(COUNT_125US - 1);
    localparam logic [15:0] SlipLast =
        (BITSLIP_HOLDOFF == 0) ? 16'd0 : 16'(BITSLIP_HOLDOFF - 1);

    typedef enum logic [1:0] {
        StHunt,
        StSlipWait,
        StLocked
    } state_e;

    // ------------------------------------------------------------------
    // Input bit ordering
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_data;
    logic [HDR_WIDTH-1:0]  w_hdr;
    logic                  w_hdr_valid;

    always_comb begin
        w_data = serdes_rx_data;
        w_hdr  = serdes_rx_hdr;
        if (BIT_REVERSE) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                w_data[i] = serdes_rx_data[DATA_WIDTH-1-i];
            end
            for (int i = 0; i < HDR_WIDTH; i++) begin
                w_hdr[i] = serdes_rx_hdr[HDR_WIDTH-1-i];
            end
        end
    end

    assign w_hdr_valid = (w_hdr == 2'b01) || (w_hdr == 2'b10);

    // ------------------------------------------------------------------
    // Descrambler: x^58 + x^39 + 1, bit 0 is first on the wire.
    // r_scr_state[k] holds the scrambled bit received k+1 bits ago.
    // ------------------------------------------------------------------
    logic [57:0]           r_scr_state;
    logic [57:0]           w_scr_next;
    logic [DATA_WIDTH-1:0] w_descr;
    logic [DATA_WIDTH-1:0] r_enc_data;
    logic [HDR_WIDTH-1:0]  r_enc_hdr;

    always_comb begin
        w_scr_next = r_scr_state;
        w_descr    = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_descr[i] = w_data[i] ^ w_scr_next[38] ^ w_scr_next[57];
            w_scr_next = {w_scr_next[56:0], w_data[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scr_state <= '1;
            r_enc_data  <= '0;
            r_enc_hdr   <= '0;
        end else begin
            r_scr_state <= w_scr_next;
            r_enc_data  <= SCRAMBLER_DISABLE ? w_data : w_descr;
            r_enc_hdr   <= w_hdr;
        end
    end

    // ------------------------------------------------------------------
    // Block lock state machine
    // ------------------------------------------------------------------
    state_e      r_state, w_state_d;
    logic [5:0]  r_sh_cnt, w_sh_cnt_d;
    logic [4:0]  r_sh_inv_cnt, w_sh_inv_cnt_d;
    logic [4:0]  w_sh_inv_inc;
    logic [15:0] r_slip_cnt, w_slip_cnt_d;
    logic        r_lock, w_lock_d;
    logic        r_bitslip, w_bitslip_d;
    logic        r_bad, w_bad_d;

    assign w_sh_inv_inc = r_sh_inv_cnt + 5'(!w_hdr_valid);

    always_comb begin
        w_state_d      = r_state;
        w_sh_cnt_d     = r_sh_cnt;
        w_sh_inv_cnt_d = r_sh_inv_cnt;
        w_slip_cnt_d   = r_slip_cnt;
        w_lock_d       = r_lock;
        w_bitslip_d    = 1'b0;
        w_bad_d        = 1'b0;
        case (r_state)
            StHunt: begin
                if (!w_hdr_valid) begin
                    w_bitslip_d    = 1'b1;
                    w_sh_cnt_d     = '0;
                    w_sh_inv_cnt_d = '0;
                    w_slip_cnt_d   = '0;
                    w_state_d      = StSlipWait;
                end else if (r_sh_cnt == 6'd63) begin
                    w_lock_d       = 1'b1;
                    w_sh_cnt_d     = '0;
                    w_sh_inv_cnt_d = '0;
                    w_state_d      = StLocked;
                end else begin
                    w_sh_cnt_d = r_sh_cnt + 6'd1;
                end
            end
            StSlipWait: begin
                // Headers are meaningless until the SERDES has realigned.
                if (r_slip_cnt == SlipLast) begin
                    w_sh_cnt_d     = '0;
                    w_sh_inv_cnt_d = '0;
                    w_state_d      = StHunt;
                end else begin
                    w_slip_cnt_d = r_slip_cnt + 16'd1;
                end
            end
            StLocked: begin
                w_bad_d = !w_hdr_valid;
                if (w_sh_inv_inc == 5'd16) begin
                    w_lock_d       = 1'b0;
                    w_bitslip_d    = 1'b1;
                    w_sh_cnt_d     = '0;
                    w_sh_inv_cnt_d = '0;
                    w_slip_cnt_d   = '0;
                    w_state_d      = StSlipWait;
                end else if (r_sh_cnt == 6'd63) begin
                    w_sh_cnt_d     = '0;
                    w_sh_inv_cnt_d = '0;
                end else begin
                    w_sh_cnt_d     = r_sh_cnt + 6'd1;
                    w_sh_inv_cnt_d = w_sh_inv_inc;
                end
            end
            default: begin
                w_state_d = StHunt;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StHunt;
            r_sh_cnt     <= '0;
            r_sh_inv_cnt <= '0;
            r_slip_cnt   <= '0;
            r_lock       <= 1'b0;
            r_bitslip    <= 1'b0;
            r_bad        <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_sh_cnt     <= w_sh_cnt_d;
            r_sh_inv_cnt <= w_sh_inv_cnt_d;
            r_slip_cnt   <= w_slip_cnt_d;
            r_lock       <= w_lock_d;
            r_bitslip    <= w_bitslip_d;
            r_bad        <= w_bad_d;
        end
    end

    // ------------------------------------------------------------------
    // BER monitor
    // ------------------------------------------------------------------
    logic [TimerW-1:0] r_ber_timer, w_ber_timer_d;
    logic [4:0]        r_ber_cnt, w_ber_cnt_d;
    logic [4:0]        w_ber_inc;
    logic              r_high_ber, w_high_ber_d;
    logic              r_status;

    assign w_ber_inc = (w_hdr_valid || (r_ber_cnt == 5'd16)) ? r_ber_cnt : r_ber_cnt + 5'd1;

    always_comb begin
        w_ber_timer_d = r_ber_timer;
        w_ber_cnt_d   = r_ber_cnt;
        w_high_ber_d  = r_high_ber;
        // Also gated on the next lock value so BER state never outlives lock.
        if (!r_lock || !w_lock_d) begin
            w_ber_timer_d = '0;
            w_ber_cnt_d   = '0;
            w_high_ber_d  = 1'b0;
        end else if (r_ber_timer == TimerLast) begin
            w_ber_timer_d = '0;
            w_ber_cnt_d   = '0;
            w_high_ber_d  = (w_ber_inc == 5'd16);
        end else begin
            w_ber_timer_d = r_ber_timer + TimerW'(1);
            w_ber_cnt_d   = w_ber_inc;
            if (w_ber_inc == 5'd16) begin
                w_high_ber_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ber_timer <= '0;
            r_ber_cnt   <= '0;
            r_high_ber  <= 1'b0;
            r_status    <= 1'b0;
        end else begin
            r_ber_timer <= w_ber_timer_d;
            r_ber_cnt   <= w_ber_cnt_d;
            r_high_ber  <= w_high_ber_d;
            r_status    <= r_lock & ~r_high_ber;
        end
    end

    assign serdes_rx_bitslip = r_bitslip;
    assign encoded_rx_data   = r_enc_data;
    assign encoded_rx_hdr    = r_enc_hdr;
    assign rx_bad_block      = r_bad;
    assign rx_block_lock     = r_lock;
    assign rx_high_ber       = r_high_ber;
    assign rx_status         = r_status;

endmodule

// File: tb/tb_eth_phy_10g_rx_sync.sv
// Scoreboard bench for eth_phy_10g_rx_sync: a bit-serial reference model predicts every
// output cycle; a monitor compares two DUT variants (normal and bit-reversed/bypassed).
module tb_eth_phy_10g_rx_sync;

    localparam int Holdoff  = 7;
    localparam int Count125 = 100;

    localparam int MHunt   = 0;
    localparam int MSlip   = 1;
    localparam int MLocked = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] rx_data = '0;
    logic [1:0]  rx_hdr = '0;

    logic        slip_a, bad_a, lock_a, hber_a, status_a;
    logic [63:0] data_a;
    logic [1:0]  hdr_a;
    logic        slip_b, bad_b, lock_b, hber_b, status_b;
    logic [63:0] data_b;
    logic [1:0]  hdr_b;

    always #5 clk = ~clk;

    eth_phy_10g_rx_sync #(
        .BITSLIP_HOLDOFF (Holdoff),
        .COUNT_125US     (Count125)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .serdes_rx_data    (rx_data),
        .serdes_rx_hdr     (rx_hdr),
        .serdes_rx_bitslip (slip_a),
        .encoded_rx_data   (data_a),
        .encoded_rx_hdr    (hdr_a),
        .rx_bad_block      (bad_a),
        .rx_block_lock     (lock_a),
        .rx_high_ber       (hber_a),
        .rx_status         (status_a)
    );

    eth_phy_10g_rx_sync #(
        .BIT_REVERSE       (1'b1),
        .SCRAMBLER_DISABLE (1'b1),
        .BITSLIP_HOLDOFF   (Holdoff),
        .COUNT_125US       (Count125)
    ) u_dut_rev (
        .clk               (clk),
        .rst               (rst),
        .serdes_rx_data    (rx_data),
        .serdes_rx_hdr     (rx_hdr),
        .serdes_rx_bitslip (slip_b),
        .encoded_rx_data   (data_b),
        .encoded_rx_hdr    (hdr_b),
        .rx_bad_block      (bad_b),
        .rx_block_lock     (lock_b),
        .rx_high_ber       (hber_b),
        .rx_status         (status_b)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  hdr;
        logic        slip;
        logic        bad;
        logic        lock;
        logic        hber;
        logic        status;
        logic [63:0] data_rev;
        logic [1:0]  hdr_rev;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state
    bit hist[$];
    bit scr_hist[$];
    int m_st, m_cnt, m_inv, m_hold, m_btim, m_bcnt;
    bit m_lock, m_hber;

    function automatic exp_t model_step(input bit r, input logic [63:0] d, input logic [1:0] h);
        exp_t e;
        bit   valid;
        bit   prev_lock;
        bit   prev_hber;
        int   n;
        e = '0;
        if (r) begin
            hist.delete();
            repeat (58) hist.push_back(1'b1);
            m_st = MHunt; m_cnt = 0; m_inv = 0; m_hold = 0;
            m_btim = 0; m_bcnt = 0; m_lock = 1'b0; m_hber = 1'b0;
            return e;
        end
        for (int i = 0; i < 64; i++) begin
            e.data[i] = d[i] ^ hist[hist.size() - 39] ^ hist[hist.size() - 58];
            hist.push_back(d[i]);
            void'(hist.pop_front());
            e.data_rev[i] = d[63 - i];
        end
        e.hdr     = h;
        e.hdr_rev = {h[0], h[1]};
        valid     = (h == 2'b01) || (h == 2'b10);
        prev_lock = m_lock;
        prev_hber = m_hber;
        e.status  = prev_lock & ~prev_hber;

        if (m_st == MHunt) begin
            if (!valid) begin
                e.slip = 1'b1; m_cnt = 0; m_inv = 0; m_hold = 0; m_st = MSlip;
            end else if (m_cnt == 63) begin
                m_lock = 1'b1; m_cnt = 0; m_inv = 0; m_st = MLocked;
            end else begin
                m_cnt++;
            end
        end else if (m_st == MSlip) begin
            m_hold++;
            if (m_hold == Holdoff) begin
                m_st = MHunt; m_cnt = 0; m_inv = 0;
            end
        end else begin
            if (!valid) begin
                e.bad = 1'b1;
                m_inv++;
            end
            if (m_inv == 16) begin
                m_lock = 1'b0; e.slip = 1'b1; m_cnt = 0; m_inv = 0; m_hold = 0; m_st = MSlip;
            end else if (m_cnt == 63) begin
                m_cnt = 0; m_inv = 0;
            end else begin
                m_cnt++;
            end
        end

        if (!prev_lock || !m_lock) begin
            m_btim = 0; m_bcnt = 0; m_hber = 1'b0;
        end else begin
            n = m_bcnt + (valid ? 0 : 1);
            if (n > 16) n = 16;
            if (m_btim == Count125 - 1) begin
                m_hber = (n >= 16);
                m_btim = 0;
                m_bcnt = 0;
            end else begin
                m_btim++;
                m_bcnt = n;
                if (n == 16) m_hber = 1'b1;
            end
        end
        e.lock = m_lock;
        e.hber = m_hber;
        return e;
    endfunction

    function automatic logic [63:0] rand_data();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [1:0] rand_valid();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] rand_invalid();
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    // Scrambles an all-zero payload so the descrambler should recover zeros.
    function automatic logic [63:0] scramble_zero();
        logic [63:0] w;
        bit          s;
        for (int i = 0; i < 64; i++) begin
            s = scr_hist[scr_hist.size() - 39] ^ scr_hist[scr_hist.size() - 58];
            scr_hist.push_back(s);
            void'(scr_hist.pop_front());
            w[i] = s;
        end
        return w;
    endfunction

    task automatic drive(input bit r, input logic [63:0] d, input logic [1:0] h);
        @(negedge clk);
        rst     = r;
        rx_data = d;
        rx_hdr  = h;
        exp_q.push_back(model_step(r, d, h));
    endtask

    task automatic run_window(input int k);
        bit bad_pos[64];
        int placed;
        placed = 0;
        while (placed < k) begin
            int p;
            p = $urandom_range(0, 63);
            if (!bad_pos[p]) begin
                bad_pos[p] = 1'b1;
                placed++;
            end
        end
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, rand_data(), bad_pos[i] ? rand_invalid() : rand_valid());
        end
    endtask

    task automatic lock_up();
        int guard;
        guard = 0;
        while (!m_lock && guard < 300) begin
            drive(1'b0, rand_data(), rand_valid());
            guard++;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                chk("encoded_rx_data", data_a, e.data);
                chk("encoded_rx_hdr", 64'(hdr_a), 64'(e.hdr));
                chk("serdes_rx_bitslip", 64'(slip_a), 64'(e.slip));
                chk("rx_bad_block", 64'(bad_a), 64'(e.bad));
                chk("rx_block_lock", 64'(lock_a), 64'(e.lock));
                chk("rx_high_ber", 64'(hber_a), 64'(e.hber));
                chk("rx_status", 64'(status_a), 64'(e.status));
                chk("rev_encoded_rx_data", data_b, e.data_rev);
                chk("rev_encoded_rx_hdr", 64'(hdr_b), 64'(e.hdr_rev));
                chk("rev_rx_block_lock", 64'(lock_b), 64'(e.lock));
            end
        end
    end

    initial begin
        repeat (4) drive(1'b1, rand_data(), rand_valid());
        // Initial lock after 64 valid headers
        repeat (64) drive(1'b0, rand_data(), rand_valid());
        // Locked: 15 bad headers hold lock, clean window, then 16 drop it
        run_window(15);
        run_window(0);
        run_window(16);
        // Into HUNT, then a burst of invalid headers spanning the holdoff
        repeat (10) drive(1'b0, rand_data(), rand_valid());
        drive(1'b0, rand_data(), 2'b00);
        repeat (7) drive(1'b0, rand_data(), rand_invalid());
        repeat (10) drive(1'b0, rand_data(), rand_invalid());
        // High BER: 8 bad headers in each of two 64-windows inside one BER window
        lock_up();
        repeat (50) drive(1'b0, rand_data(), rand_valid());
        repeat (8) drive(1'b0, rand_data(), rand_invalid());
        repeat (6) drive(1'b0, rand_data(), rand_valid());
        repeat (8) drive(1'b0, rand_data(), rand_invalid());
        repeat (260) drive(1'b0, rand_data(), rand_valid());
        // Scrambled idle payload
        scr_hist.delete();
        repeat (58) scr_hist.push_back(1'($urandom_range(0, 1)));
        repeat (10) drive(1'b0, scramble_zero(), 2'b10);
        // Reset pulse while locked, then relock
        drive(1'b1, rand_data(), rand_valid());
        repeat (70) drive(1'b0, rand_data(), rand_valid());
        // Random mix
        repeat (400) begin
            drive(1'b0, rand_data(), ($urandom_range(0, 19) == 0) ? rand_invalid() : rand_valid());
        end
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
